framer_burst_sched: RTL and testbench
=====================================

FRAMER_BURST_SCHED -- requirements
Module: framer_burst_sched

Interface
REQ-001 SHALL have parameter SR_FRAME_LEN, default 0, settings address of framer frame length.
REQ-002 SHALL have parameter SR_GAP_LEN, default 1, settings address of framer gap length.
REQ-003 SHALL have parameter SR_OFFSET, default 2, settings address of framer trigger offset.
REQ-004 SHALL have parameter SR_NUMBER_SYMBOLS_SHORT, default 4, settings address of framer burst symbol count.
REQ-005 SHALL have parameter TIMEOUT_W, default 24, width of timeout counter.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have port clear  input  1  synchronous active-high soft clear, same effect as reset.
REQ-009 SHALL have port req_valid  input  2  burst request per requester (index 0, 1).
REQ-010 SHALL have port req_ready  output  2  one-hot, one-cycle accept of a request.
REQ-011 SHALL have port req_cfg  input  128  per requester 64 bits {frame_len[63:48], gap_len[47:32], offset[31:16], numsymbols[15:0]}; requester 1 in [127:64].
REQ-012 SHALL have port set_stb / set_addr / set_data  output  1 / 8 / 32  settings-bus write to framer, all registered.
REQ-013 SHALL have port framer_sof, framer_eof  input  1 each  framer level-sticky frame-start / burst-end flags.
REQ-014 SHALL have port timeout_cycles  input  TIMEOUT_W  wait limit; 0 disables timeout.
REQ-015 SHALL have port done_valid / done_ready  output / input  1 / 1  completion handshake.
REQ-016 SHALL have port done_id / done_status  output  1 / 2  served requester; 00 ok, 01 timeout, 10 bad config.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, WR_FRAME, WR_GAP, WR_OFFSET, WR_NSYM, WAIT_SOF, WAIT_EOF, REPORT.
REQ-019 IDLE: if any req_valid, SHALL grant round-robin (favour requester not served last; single requester always granted), pulse req_ready for that bit in that cycle, capture its req_cfg, update last-served pointer.
REQ-020 On grant with captured frame_len==0, SHALL go to REPORT with status 10, no settings writes.
REQ-021 Otherwise SHALL emit four back-to-back set_stb cycles starting the cycle after grant, in order WR_FRAME, WR_GAP, WR_OFFSET, WR_NSYM, set_addr = matching SR_* parameter, set_data = {16'h0, field}.
REQ-022 set_stb SHALL be 0 in all other states; set_addr/set_data values outside writes are don't-care.
REQ-023 SHALL register framer_sof/framer_eof and detect rising edges (0 then 1); edges seen outside WAIT states SHALL be ignored.
REQ-024 WAIT_SOF: on sof rising edge SHALL go to WAIT_EOF; WAIT_EOF: on eof rising edge SHALL go to REPORT status 00.
REQ-025 Timeout counter SHALL zero on entry to WAIT_SOF, count every cycle in WAIT_SOF and WAIT_EOF (not reset between them), saturating; when timeout_cycles!=0 and count reaches timeout_cycles-1 SHALL go to REPORT status 01.
REQ-026 Eof edge and timeout in same cycle SHALL report 00.
REQ-027 REPORT: done_valid=1 with stable done_id/done_status until done_ready=1; transfer returns to IDLE next cycle; new grant no earlier than the cycle after.
REQ-028 req_valid changes while busy SHALL be ignored; requests remain pending until granted.

Reset
REQ-029 On reset low or clear high SHALL enter IDLE; req_ready=0, set_stb=0, set_addr=0, set_data=0, done_valid=0, done_id=0, done_status=00, busy=0, timeout count=0, edge registers=0, pointer favours requester 0.
REQ-030 Reset/clear mid-write or mid-wait SHALL abort immediately with no further set_stb and no done report.

Verification
REQ-031 Req0 cfg {64,16,3,10}, sof edge at +20, eof edge at +500 -> req_ready[0] pulse, set_stb addr 0,1,2,4 data 64,16,3,10 in cycles 1-4, done_id=0 status 00.
REQ-032 Both requesters valid continuously, instant sof/eof -> grants alternate 0,1,0,1.
REQ-033 timeout_cycles=100, no sof -> done_status 01 exactly 100 cycles after WAIT_SOF entry; timeout_cycles=0 -> waits indefinitely.
REQ-034 Req1 frame_len=0 -> no set_stb, done_id=1 status 10.
REQ-035 Eof rising at timeout cycle -> status 00; done_ready held low 5 cycles -> done outputs stable, then IDLE.
REQ-036 reset low during WR_GAP -> next cycle IDLE, set_stb 0, no done_valid.

Source files
------------

// File: rtl/framer_burst_sched.sv
// Burst scheduler: arbitrates two requesters, programs the framer over the
// settings bus, then waits for frame start/end and reports completion.
module framer_burst_sched #(
  parameter int SR_FRAME_LEN            = 0,
  parameter int SR_GAP_LEN              = 1,
  parameter int SR_OFFSET               = 2,
  parameter int SR_NUMBER_SYMBOLS_SHORT = 4,
  parameter int TIMEOUT_W               = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [127:0]         req_cfg,
  output logic                 set_stb,
  output logic [7:0]           set_addr,
  output logic [31:0]          set_data,
  input  logic                 framer_sof,
  input  logic                 framer_eof,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic                 done_id,
  output logic [1:0]           done_status,
  output logic                 busy
);

  localparam logic [7:0] A_FRAME = 8'(SR_FRAME_LEN);
  localparam logic [7:0] A_GAP   = 8'(SR_GAP_LEN);
  localparam logic [7:0] A_OFF   = 8'(SR_OFFSET);
  localparam logic [7:0] A_NSYM  = 8'(SR_NUMBER_SYMBOLS_SHORT);

  typedef enum logic [2:0] {
    IDLE,
    WR_FRAME,
    WR_GAP,
    WR_OFFSET,
    WR_NSYM,
    WAIT_SOF,
    WAIT_EOF,
    REPORT
  } state_t;

  state_t               state;
  logic                 last;
  logic [47:0]          cfg_q;
  logic [TIMEOUT_W-1:0] tcnt;
  logic                 sof_q;
  logic                 eof_q;

  logic        rst_hit;
  logic        any_req;
  logic        gnt_id;
  logic [63:0] sel_cfg;
  logic        sof_rise;
  logic        eof_rise;
  logic        tmo_hit;

  assign rst_hit  = !reset || clear;
  assign any_req  = |req_valid;
  assign sel_cfg  = gnt_id ? req_cfg[127:64] : req_cfg[63:0];
  assign sof_rise = framer_sof & ~sof_q;
  assign eof_rise = framer_eof & ~eof_q;
  assign tmo_hit  = (timeout_cycles != '0) &&
                    (tcnt == timeout_cycles - TIMEOUT_W'(1));
  assign busy     = (state != IDLE);

  // `last` holds the requester served most recently; ties go to the other.
  always_comb begin
    gnt_id = req_valid[1];
    if (&req_valid) gnt_id = ~last;
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !rst_hit && any_req)
      req_ready = gnt_id ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst_hit) begin
      state       <= IDLE;
      last        <= 1'b1;
      cfg_q       <= '0;
      tcnt        <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      set_stb     <= 1'b0;
      set_addr    <= '0;
      set_data    <= '0;
      done_valid  <= 1'b0;
      done_id     <= 1'b0;
      done_status <= 2'b00;
    end else begin
      sof_q <= framer_sof;
      eof_q <= framer_eof;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            last    <= gnt_id;
            cfg_q   <= sel_cfg[47:0];
            done_id <= gnt_id;
            if (sel_cfg[63:48] == 16'h0) begin
              state       <= REPORT;
              done_valid  <= 1'b1;
              done_status <= 2'b10;
            end else begin
              state    <= WR_FRAME;
              set_stb  <= 1'b1;
              set_addr <= A_FRAME;
              set_data <= {16'h0, sel_cfg[63:48]};
            end
          end
        end
        WR_FRAME: begin
          state    <= WR_GAP;
          set_addr <= A_GAP;
          set_data <= {16'h0, cfg_q[47:32]};
        end
        WR_GAP: begin
          state    <= WR_OFFSET;
          set_addr <= A_OFF;
          set_data <= {16'h0, cfg_q[31:16]};
        end
        WR_OFFSET: begin
          state    <= WR_NSYM;
          set_addr <= A_NSYM;
          set_data <= {16'h0, cfg_q[15:0]};
        end
        WR_NSYM: begin
          state   <= WAIT_SOF;
          set_stb <= 1'b0;
          tcnt    <= '0;
        end
        WAIT_SOF: begin
          if (tcnt != '1) tcnt <= tcnt + TIMEOUT_W'(1);
          if (tmo_hit) begin
            state       <= REPORT;
            done_valid  <= 1'b1;
            done_status <= 2'b01;
          end else if (sof_rise) begin
            state <= WAIT_EOF;
          end
        end
        WAIT_EOF: begin
          if (tcnt != '1) tcnt <= tcnt + TIMEOUT_W'(1);
          // A burst that ends on the deadline cycle still counts as done.
          if (eof_rise) begin
            state       <= REPORT;
            done_valid  <= 1'b1;
            done_status <= 2'b00;
          end else if (tmo_hit) begin
            state       <= REPORT;
            done_valid  <= 1'b1;
            done_status <= 2'b01;
          end
        end
        REPORT: begin
          if (done_ready) begin
            state      <= IDLE;
            done_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framer_burst_sched.sv
// Self-checking bench for framer_burst_sched: directed scenarios plus
// randomized bursts against a timing model of the scheduling rules.
module tb_framer_burst_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_cfg;
  logic         set_stb;
  logic [7:0]   set_addr;
  logic [31:0]  set_data;
  logic         framer_sof;
  logic         framer_eof;
  logic [23:0]  timeout_cycles;
  logic         done_valid;
  logic         done_ready;
  logic         done_id;
  logic [1:0]   done_status;
  logic         busy;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic [1:0] pend;
  logic       m_last;

  always #5 clk = ~clk;

  framer_burst_sched dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cfg(req_cfg),
    .set_stb(set_stb),
    .set_addr(set_addr),
    .set_data(set_data),
    .framer_sof(framer_sof),
    .framer_eof(framer_eof),
    .timeout_cycles(timeout_cycles),
    .done_valid(done_valid),
    .done_ready(done_ready),
    .done_id(done_id),
    .done_status(done_status),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_addr(input int i);
    case (i)
      0:       return 8'd0;
      1:       return 8'd1;
      2:       return 8'd2;
      default: return 8'd4;
    endcase
  endfunction

  // Wait-phase cycles are numbered from WAIT_SOF entry (k=0). The deadline
  // is cycle T-1; an eof edge on or before it wins, otherwise timeout.
  task automatic exp_done(input int t, input int s, input int e,
                          output int r, output logic [1:0] st);
    if (t != 0 && s >= t - 1) begin
      r = t - 1; st = 2'b01;
    end else if (t != 0 && e > t - 1) begin
      r = t - 1; st = 2'b01;
    end else begin
      r = e; st = 2'b00;
    end
  endtask

  function automatic logic [63:0] rcfg();
    logic [63:0] c;
    c = {$urandom, $urandom};
    if ($urandom_range(0, 4) == 0) c[63:48] = 16'h0;
    else if (c[63:48] == 16'h0) c[63:48] = 16'h1;
    return c;
  endfunction

  task automatic txn(input logic [1:0] newreq, input logic [63:0] c0,
                     input logic [63:0] c1, input int tmo, input int s,
                     input int e, input int h);
    logic        g;
    logic [63:0] cfg;
    int          r;
    logic [1:0]  st;
    pend           = pend | newreq;
    req_valid      = pend;
    req_cfg        = {c1, c0};
    timeout_cycles = 24'(tmo);
    done_ready     = 1'b0;
    framer_sof     = 1'b0;
    framer_eof     = 1'b0;
    #1;
    g = (pend == 2'b11) ? ~m_last : pend[1];
    check("grant", req_ready, g ? 2'b10 : 2'b01);
    check("idle_busy", busy, 1'b0);
    cfg    = g ? c1 : c0;
    m_last = g;
    step();
    pend[g]   = 1'b0;
    req_valid = pend;
    req_cfg   = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("ready_busy", req_ready, 2'b00);
    if (cfg[63:48] == 16'h0) begin
      st = 2'b10;
      check("badcfg_stb", set_stb, 1'b0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        check("wr_stb", set_stb, 1'b1);
        check("wr_addr", set_addr, exp_addr(i));
        check("wr_data", set_data, {16'h0, cfg[63-16*i -: 16]});
        step();
      end
      exp_done(tmo, s, e, r, st);
      for (int k = 0; k <= r; k++) begin
        framer_sof = (k >= s);
        framer_eof = (k >= e);
        #1;
        check("wait", {busy, set_stb, done_valid}, 3'b100);
        step();
      end
    end
    for (int j = 0; j <= h; j++) begin
      if (j == h) done_ready = 1'b1;
      #1;
      check("done", {busy, done_valid, done_id, done_status},
            {1'b1, 1'b1, g, st});
      step();
    end
    done_ready = 1'b0;
    framer_sof = 1'b0;
    framer_eof = 1'b0;
    #1;
    check("back_idle", {busy, done_valid, set_stb}, 3'b000);
  endtask

  task automatic abort_txn(input logic [1:0] newreq, input logic [63:0] c0,
                           input logic [63:0] c1, input int at,
                           input logic use_clear);
    logic g;
    pend           = pend | newreq;
    req_valid      = pend;
    req_cfg        = {c1, c0};
    timeout_cycles = 24'd0;
    done_ready     = 1'b0;
    #1;
    g = (pend == 2'b11) ? ~m_last : pend[1];
    check("ab_grant", req_ready, g ? 2'b10 : 2'b01);
    m_last = g;
    step();
    pend[g]   = 1'b0;
    req_valid = pend;
    for (int k = 1; k < at; k++) step();
    check("ab_pre_busy", busy, 1'b1);
    check("ab_pre_stb", set_stb, (at >= 1 && at <= 4) ? 1'b1 : 1'b0);
    if (at == 2) check("ab_pre_addr", set_addr, 8'd1);
    if (use_clear) clear = 1'b1;
    else reset = 1'b0;
    step();
    check("ab_post", {busy, set_stb, done_valid, req_ready}, 5'b0);
    check("ab_post_bus", {set_addr, set_data}, 40'h0);
    check("ab_post_done", {done_id, done_status}, 3'b0);
    clear  = 1'b0;
    reset  = 1'b1;
    m_last = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    clear          = 1'b0;
    req_valid      = 2'b11;
    req_cfg        = '0;
    framer_sof     = 1'b0;
    framer_eof     = 1'b0;
    timeout_cycles = '0;
    done_ready     = 1'b0;
    pend           = 2'b00;
    m_last         = 1'b1;
    repeat (3) step();
    check("rst_ready", req_ready, 2'b00);
    check("rst_ctl", {busy, set_stb, done_valid}, 3'b000);
    check("rst_bus", {set_addr, set_data}, 40'h0);
    check("rst_done", {done_id, done_status}, 3'b000);
    req_valid = 2'b00;
    reset     = 1'b1;
    step();
    check("idle_noreq", {busy, req_ready}, 3'b000);

    txn(2'b01, {16'd64, 16'd16, 16'd3, 16'd10}, rcfg(), 0, 20, 500, 0);

    for (int i = 0; i < 4; i++)
      txn(2'b11, rcfg() | 64'h0001_0000_0000_0000,
          rcfg() | 64'h0001_0000_0000_0000, 0, 0, 1, 0);

    txn(2'b01, 64'h0008_0002_0001_0005, 64'h0008_0002_0001_0005,
        100, 1000000, 1000000, 0);
    txn(2'b00, 64'h0010_0001_0001_0001, 64'h0010_0001_0001_0001,
        0, 300, 310, 1);

    txn(2'b10, 64'h0004_0001_0001_0001, 64'h0000_1234_5678_9abc,
        0, 0, 1, 2);

    txn(2'b01, 64'h0020_0004_0002_0003, 64'h0020_0004_0002_0003,
        50, 10, 49, 5);

    abort_txn(2'b01, 64'h0040_0010_0003_000a, 64'h0, 2, 1'b0);
    abort_txn(2'b10, 64'h0, 64'h0040_0010_0003_000a, 8, 1'b1);
    txn(2'b11, 64'h0002_0002_0002_0002, 64'h0003_0003_0003_0003,
        0, 0, 1, 0);

    for (int i = 0; i < 14; i++) begin
      logic [1:0] nr;
      int t, s, e;
      nr = 2'($urandom_range(0, 3));
      if ((pend | nr) == 2'b00) nr = 2'b01;
      t = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(5, 60));
      s = int'($urandom_range(0, 40));
      e = s + 1 + int'($urandom_range(0, 40));
      txn(nr, rcfg(), rcfg(), t, s, e, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
